act_pwl_pipe: RTL

Pipelined, parametrised piecewise-linear activation unit for the LSTM datapath. Evaluates sigmoid or tanh on a signed fixed-point operand using a three-segment approximation with slopes 1/4, 1/8 and 0. Sits between the gate pre-activation accumulators and the cell/state update logic, with a valid/ready stream on both sides. The per-sample `in_mode` bit lets a single instance serve gate (sigmoid) and candidate (tanh) paths.

---
 rtl/act_pwl_pipe.sv | 134 +++++++++++++
 1 files changed

// File: rtl/act_pwl_pipe.sv
// act_pwl_pipe: three-stage piecewise-linear sigmoid/tanh unit with valid/ready
// streaming on both sides. One enable advances the whole pipe, so backpressure
// stalls every stage together and bubbles travel with the data.
// Optional macro ACT_DERIV_EN adds out_deriv, the slope of the approximation,
// aligned with out_data.
module act_pwl_pipe #(
  parameter int WIDTH = 24,
  parameter int FRAC  = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef ACT_DERIV_EN
  ,
  output logic [WIDTH-1:0] out_deriv
`endif
);

  localparam int    STAGES = 3;
  localparam longint ONE_L = longint'(1) << FRAC;
  localparam longint T08_L = (4 * ONE_L) / 5;
  localparam longint T32_L = (16 * ONE_L) / 5;
  localparam longint C04_L = (2 * ONE_L) / 5;
  localparam longint C06_L = (3 * ONE_L) / 5;

  localparam logic signed [WIDTH-1:0] ONE  = ONE_L[WIDTH-1:0];
  localparam logic signed [WIDTH-1:0] HALF = ONE_L[WIDTH:1];
  localparam logic signed [WIDTH-1:0] T08  = T08_L[WIDTH-1:0];
  localparam logic signed [WIDTH-1:0] T32  = T32_L[WIDTH-1:0];
  localparam logic signed [WIDTH-1:0] NT08 = -T08;
  localparam logic signed [WIDTH-1:0] NT32 = -T32;
  localparam logic signed [WIDTH-1:0] C04  = C04_L[WIDTH-1:0];
  localparam logic signed [WIDTH-1:0] C06  = C06_L[WIDTH-1:0];
  localparam logic signed [WIDTH-1:0] MAXV = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {R_A, R_BP, R_BN, R_SP, R_SN} region_t;

  logic [STAGES:1]         vld_pipe;
  logic                    en;
  logic signed [WIDTH-1:0] z_n, z1, s_n, s2;
  region_t                 reg_n, reg1;
  logic                    m1, m2;

  assign en        = out_ready | ~out_valid;
  assign in_ready  = en;
  assign out_valid = vld_pipe[STAGES];

  // Operand doubling for tanh (saturating) and signed region classification;
  // no absolute value so the most negative input needs no special case.
  always_comb begin
    z_n = in_data;
    if (in_mode) begin
      if (in_data[WIDTH-1] != in_data[WIDTH-2])
        z_n = in_data[WIDTH-1] ? MINV : MAXV;
      else
        z_n = {in_data[WIDTH-2:0], 1'b0};
    end
    reg_n = R_A;
    if (z_n >= T32)       reg_n = R_SP;
    else if (z_n > T08)   reg_n = R_BP;
    else if (z_n <= NT32) reg_n = R_SN;
    else if (z_n < NT08)  reg_n = R_BN;
  end

  // Segment evaluation of the sigmoid-shaped value s from the stage-1 operand.
  always_comb begin
    case (reg1)
      R_A:     s_n = (z1 >>> 2) + HALF;
      R_BP:    s_n = (z1 >>> 3) + C06;
      R_BN:    s_n = (z1 >>> 3) + C04;
      R_SP:    s_n = ONE;
      default: s_n = '0;
    endcase
  end

  // Valid shift register; a sample enters only when the pipe advances.
  always_ff @(posedge clk) begin
    if (rst)     vld_pipe <= '0;
    else if (en) vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
  end

  // Data stages: operand/region/mode, then s, then the final activation.
  always_ff @(posedge clk) begin
    if (rst) begin
      z1       <= '0;
      reg1     <= R_A;
      m1       <= 1'b0;
      s2       <= '0;
      m2       <= 1'b0;
      out_data <= '0;
    end else if (en) begin
      z1       <= z_n;
      reg1     <= reg_n;
      m1       <= in_mode;
      s2       <= s_n;
      m2       <= m1;
      out_data <= m2 ? (s2 <<< 1) - ONE : s2;
    end
  end

`ifdef ACT_DERIV_EN
  logic [WIDTH-1:0] d_n, d2;

  // Slope per region; tanh slopes are 4x sigmoid's because of the 2x operand
  // and the 2s-1 output scaling.
  always_comb begin
    case (reg1)
      R_A:     d_n = m1 ? ONE : (ONE >>> 2);
      R_BP,
      R_BN:    d_n = m1 ? (ONE >>> 1) : (ONE >>> 3);
      default: d_n = '0;
    endcase
  end

  // Derivative registers run alongside s and out_data.
  always_ff @(posedge clk) begin
    if (rst) begin
      d2        <= '0;
      out_deriv <= '0;
    end else if (en) begin
      d2        <= d_n;
      out_deriv <= d2;
    end
  end
`endif

endmodule
